// File: rtl/id_operand_stage.sv
// id_operand_stage: decode-stage operand fetch and ID/EX pipeline register.
//   - Register-file read addresses come straight from the rs/rt indices.
//   - EX/MEM/WB results are forwarded over the register-file read data.
//     The nearest producer wins, and index 0 always reads as zero.
//   - A load in EX followed by a dependent instruction in ID raises a
//     one-cycle stall. After that, the MEM forward supplies the loaded value.
//   - Operands and control move into EX after one cycle. A bubble is
//     inserted on flush or stall. A global hold freezes EX, and a flush seen
//     during a hold is remembered until the hold drops.
// Optional build macro HAZARD_STAT_EN: adds the stat_stall/stat_flush event
// counters. If the macro is not defined, the counters do not exist.
module id_operand_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [AW-1:0] id_rd,
  input  logic          id_we,
  input  logic          id_load,
  input  logic [DW-1:0] id_imm,
  output logic [AW-1:0] rf_ra,
  output logic [AW-1:0] rf_rb,
  input  logic [DW-1:0] rf_da,
  input  logic [DW-1:0] rf_db,
  input  logic [DW-1:0] ex_res,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic          flush,
  input  logic          hold,
  output logic          stall,
`ifdef HAZARD_STAT_EN
  output logic [DW-1:0] stat_stall,
  output logic [DW-1:0] stat_flush,
`endif
  output logic          ex_valid,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_imm,
  output logic [AW-1:0] ex_rd,
  output logic          ex_we,
  output logic          ex_load
);

  logic          ex_valid_q, ex_valid_d;
  logic          ex_we_q, ex_we_d;
  logic          ex_load_q, ex_load_d;
  logic [AW-1:0] ex_rd_q, ex_rd_d;
  logic [DW-1:0] ex_a_q, ex_a_d;
  logic [DW-1:0] ex_b_q, ex_b_d;
  logic [DW-1:0] ex_imm_q, ex_imm_d;
  logic          flush_pend_q, flush_pend_d;
  logic          ex_fwd_ok;
  logic          haz;
  logic [DW-1:0] op_a, op_b;

  // Forwarding priority: zero register, then EX, then MEM, then WB, then the RF.
  // WB is included because the RF write lands on the same edge as this read.
  function automatic logic [DW-1:0] bypass(
    input logic [AW-1:0] src,
    input logic [DW-1:0] rf_data,
    input logic          ex_ok,
    input logic [AW-1:0] ex_dst,
    input logic [DW-1:0] ex_val,
    input logic          m_we,
    input logic [AW-1:0] m_dst,
    input logic [DW-1:0] m_val,
    input logic          w_we,
    input logic [AW-1:0] w_dst,
    input logic [DW-1:0] w_val
  );
    if (src == '0)                    return '0;
    else if (ex_ok && ex_dst == src)  return ex_val;
    else if (m_we && m_dst == src)    return m_val;
    else if (w_we && w_dst == src)    return w_val;
    else                              return rf_data;
  endfunction

  assign rf_ra = id_rs;
  assign rf_rb = id_rt;

  // A load still in EX has no result yet, so it is never forwarded from EX.
  assign ex_fwd_ok = ex_valid_q & ex_we_q & ~ex_load_q;

  // Compute the operands and the load-use hazard from the current pipeline state.
  always_comb begin
    op_a = bypass(id_rs, rf_da, ex_fwd_ok, ex_rd_q, ex_res,
                  mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data);
    op_b = bypass(id_rt, rf_db, ex_fwd_ok, ex_rd_q, ex_res,
                  mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data);
    haz  = id_valid & ex_valid_q & ex_load_q & (ex_rd_q != '0) &
           ((id_use_rs & (ex_rd_q == id_rs)) | (id_use_rt & (ex_rd_q == id_rt)));
  end

  // Flush (now or pending) overrides stall. Stall is forced low during reset.
  assign stall = haz & ~flush & ~flush_pend_q & rst_n;

  // Next state of the ID/EX register: hold, then flush bubble, then stall bubble, then load.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_we_d      = ex_we_q;
    ex_load_d    = ex_load_q;
    ex_rd_d      = ex_rd_q;
    ex_a_d       = ex_a_q;
    ex_b_d       = ex_b_q;
    ex_imm_d     = ex_imm_q;
    flush_pend_d = flush_pend_q;
    if (hold) begin
      if (flush) flush_pend_d = 1'b1;
    end else if (flush || flush_pend_q || stall) begin
      ex_valid_d   = 1'b0;
      ex_we_d      = 1'b0;
      ex_load_d    = 1'b0;
      ex_rd_d      = '0;
      ex_a_d       = '0;
      ex_b_d       = '0;
      ex_imm_d     = '0;
      flush_pend_d = 1'b0;
    end else begin
      ex_valid_d = id_valid;
      ex_we_d    = id_we & id_valid;
      ex_load_d  = id_load & id_valid;
      ex_rd_d    = id_rd;
      ex_a_d     = op_a;
      ex_b_d     = op_b;
      ex_imm_d   = id_imm;
    end
  end

  // ID/EX pipeline register and the pending-flush flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_we_q      <= 1'b0;
      ex_load_q    <= 1'b0;
      ex_rd_q      <= '0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_imm_q     <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_we_q      <= ex_we_d;
      ex_load_q    <= ex_load_d;
      ex_rd_q      <= ex_rd_d;
      ex_a_q       <= ex_a_d;
      ex_b_q       <= ex_b_d;
      ex_imm_q     <= ex_imm_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_we    = ex_we_q;
  assign ex_load  = ex_load_q;
  assign ex_rd    = ex_rd_q;
  assign ex_a     = ex_a_q;
  assign ex_b     = ex_b_q;
  assign ex_imm   = ex_imm_q;

`ifdef HAZARD_STAT_EN
  logic [DW-1:0] stat_stall_q, stat_stall_d;
  logic [DW-1:0] stat_flush_q, stat_flush_d;

  // Count stall bubbles and flush bubbles. Hold cycles insert neither, so they are not counted.
  always_comb begin
    stat_stall_d = stat_stall_q;
    stat_flush_d = stat_flush_q;
    if (!hold && stall)                      stat_stall_d = stat_stall_q + DW'(1);
    if (!hold && (flush || flush_pend_q))    stat_flush_d = stat_flush_q + DW'(1);
  end

  // Hazard event counters; they wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_q <= '0;
      stat_flush_q <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_flush_q <= stat_flush_d;
    end
  end

  assign stat_stall = stat_stall_q;
  assign stat_flush = stat_flush_q;
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed scenarios followed by random traffic.
// A behavioural model of the EX slot is kept alongside the DUT.
module tb_id_operand_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_use_rs, id_use_rt, id_we, id_load;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [DW-1:0] id_imm, rf_da, rf_db, ex_res, mem_data, wb_data;
  logic          mem_we, wb_we, flush, hold;
  logic [AW-1:0] mem_rd, wb_rd;
  logic [AW-1:0] rf_ra, rf_rb;
  logic          stall, ex_valid, ex_we, ex_load;
  logic [DW-1:0] ex_a, ex_b, ex_imm;
  logic [AW-1:0] ex_rd;
`ifdef HAZARD_STAT_EN
  logic [DW-1:0] stat_stall, stat_flush;
  int unsigned   m_sst, m_sfl;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic          valid;
    logic          we;
    logic          load;
    logic [AW-1:0] rd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
  } slot_t;

  slot_t m_ex;
  logic  m_fp;

  always #5 clk = ~clk;

  id_operand_stage #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load), .id_imm(id_imm),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_da(rf_da), .rf_db(rf_db),
    .ex_res(ex_res),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .hold(hold), .stall(stall),
`ifdef HAZARD_STAT_EN
    .stat_stall(stat_stall), .stat_flush(stat_flush),
`endif
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_load(ex_load)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: value a source index should read, given the producers in flight.
  function automatic logic [DW-1:0] m_byp(input logic [AW-1:0] x, input logic [DW-1:0] rf);
    if (x == 0) return '0;
    if (m_ex.valid && m_ex.we && !m_ex.load && m_ex.rd == x) return ex_res;
    if (mem_we && mem_rd == x) return mem_data;
    if (wb_we && wb_rd == x) return wb_data;
    return rf;
  endfunction

  function automatic logic m_stall();
    logic dep;
    dep = (id_use_rs && id_rs == m_ex.rd) || (id_use_rt && id_rt == m_ex.rd);
    return rst_n && id_valid && m_ex.valid && m_ex.load && m_ex.rd != 0 && dep
           && !flush && !m_fp;
  endfunction

  task automatic model_reset();
    m_ex = '{valid: 1'b0, we: 1'b0, load: 1'b0, rd: '0, a: '0, b: '0, imm: '0};
    m_fp = 1'b0;
`ifdef HAZARD_STAT_EN
    m_sst = 0;
    m_sfl = 0;
`endif
  endtask

  task automatic model_update();
    slot_t bubble, nxt;
    logic  st;
    bubble = '{valid: 1'b0, we: 1'b0, load: 1'b0, rd: '0, a: '0, b: '0, imm: '0};
    st = m_stall();
    nxt = '{valid: id_valid, we: id_we && id_valid, load: id_load && id_valid,
            rd: id_rd, a: m_byp(id_rs, rf_da), b: m_byp(id_rt, rf_db), imm: id_imm};
`ifdef HAZARD_STAT_EN
    if (!hold && st) m_sst++;
    if (!hold && (flush || m_fp)) m_sfl++;
`endif
    if (hold) begin
      if (flush) m_fp = 1'b1;
    end else if (flush || m_fp) begin
      m_ex = bubble;
      m_fp = 1'b0;
    end else if (st) begin
      m_ex = bubble;
    end else begin
      m_ex = nxt;
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".ex_valid"}, DW'(ex_valid), DW'(m_ex.valid));
    chk({tag, ".ex_we"},    DW'(ex_we),    DW'(m_ex.we));
    chk({tag, ".ex_load"},  DW'(ex_load),  DW'(m_ex.load));
    chk({tag, ".ex_rd"},    DW'(ex_rd),    DW'(m_ex.rd));
    chk({tag, ".ex_imm"},   ex_imm,        m_ex.imm);
    if (m_ex.valid) begin
      chk({tag, ".ex_a"}, ex_a, m_ex.a);
      chk({tag, ".ex_b"}, ex_b, m_ex.b);
    end
`ifdef HAZARD_STAT_EN
    chk({tag, ".stat_stall"}, stat_stall, DW'(m_sst));
    chk({tag, ".stat_flush"}, stat_flush, DW'(m_sfl));
`endif
  endtask

  // Let combinational outputs settle after the inputs change, then check them.
  task automatic settle(input string tag);
    #1;
    chk({tag, ".stall"}, DW'(stall), DW'(m_stall()));
    chk({tag, ".rf_ra"}, DW'(rf_ra), DW'(id_rs));
    chk({tag, ".rf_rb"}, DW'(rf_rb), DW'(id_rt));
  endtask

  // Cross one rising edge and check the registered outputs on the falling edge.
  task automatic clock(input string tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_regs(tag);
  endtask

  task automatic clr();
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_rd = 0; id_we = 0; id_load = 0; id_imm = 0;
    rf_da = 0; rf_db = 0; ex_res = 0;
    mem_we = 0; mem_rd = 0; mem_data = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
    flush = 0; hold = 0;
  endtask

  task automatic instr(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic urs, input logic urt, input logic [AW-1:0] rd,
                       input logic we, input logic ld, input logic [DW-1:0] imm);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_we = we; id_load = ld; id_imm = imm;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a load-use stall.
    instr(1, 0, 0, 0, 0, 5'd3, 1, 1, 32'h0000_00AA); settle("rst_lw"); clock("rst_lw");
    instr(1, 5'd1, 5'd3, 1, 1, 5'd7, 1, 0, 32'h0); settle("rst_use");
    chk("rst_pre_stall", DW'(stall), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_stall", DW'(stall), 0);
    chk("rst_ex_valid", DW'(ex_valid), 0);
    chk("rst_ex_imm", ex_imm, 0);
    chk("rst_ex_rd", DW'(ex_rd), 0);
    check_regs("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    settle("rst_rel"); clock("rst_rel");
    chk("rst_rel_valid", DW'(ex_valid), 0);
    chk("rst_rel_load", DW'(ex_load), 0);

    // Forwarding priority for rs = 5.
    clr();
    instr(1, 0, 0, 0, 0, 5'd5, 1, 0, 32'h0); settle("byp_setup"); clock("byp_setup");
    instr(1, 5'd5, 0, 1, 0, 5'd6, 0, 0, 32'h0);
    ex_res = 32'h11; mem_we = 1; mem_rd = 5; mem_data = 32'h22;
    wb_we = 1; wb_rd = 5; wb_data = 32'h33; rf_da = 32'h44;
    settle("byp_all"); clock("byp_all"); chk("byp_all_a", ex_a, 32'h11);
    settle("byp_mw"); clock("byp_mw"); chk("byp_mw_a", ex_a, 32'h22);
    mem_we = 0;
    settle("byp_w"); clock("byp_w"); chk("byp_w_a", ex_a, 32'h33);
    wb_we = 0; id_we = 1; id_rd = 5;
    settle("byp_none"); clock("byp_none"); chk("byp_none_a", ex_a, 32'h44);
    mem_we = 1; wb_we = 1; id_rs = 0;
    settle("byp_r0"); clock("byp_r0"); chk("byp_r0_a", ex_a, 32'h0);

    // Load-use: one stall, then the MEM forward supplies the loaded value.
    clr();
    instr(1, 0, 0, 0, 0, 5'd3, 1, 1, 32'h0); settle("lu_lw"); clock("lu_lw");
    instr(1, 5'd1, 5'd3, 0, 1, 5'd8, 1, 0, 32'h0); rf_db = 32'h1234_5678;
    settle("lu_use"); chk("lu_stall1", DW'(stall), 1);
    clock("lu_use"); chk("lu_bubble", DW'(ex_valid), 0);
    mem_we = 1; mem_rd = 3; mem_data = 32'hDEAD_BEEF;
    settle("lu_fwd"); chk("lu_stall0", DW'(stall), 0);
    clock("lu_fwd"); chk("lu_ex_b", ex_b, 32'hDEAD_BEEF);
    chk("lu_valid", DW'(ex_valid), 1);

    // Flush and hazard together: the flush wins.
    clr();
    instr(1, 0, 0, 0, 0, 5'd3, 1, 1, 32'h0); settle("fs_lw"); clock("fs_lw");
    instr(1, 0, 5'd3, 0, 1, 5'd9, 1, 0, 32'h0); flush = 1;
    settle("fs_use"); chk("fs_stall", DW'(stall), 0);
    clock("fs_use"); chk("fs_bubble", DW'(ex_valid), 0);

    // Hold for 3 cycles with a flush in the 2nd cycle.
    clr();
    instr(1, 0, 0, 0, 0, 5'd9, 1, 0, 32'h1234); settle("hd_fill"); clock("hd_fill");
    instr(1, 0, 0, 0, 0, 5'd11, 1, 0, 32'hAAAA); hold = 1;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      settle("hd_frz"); clock("hd_frz");
      chk("hd_imm", ex_imm, 32'h1234);
      chk("hd_rd", DW'(ex_rd), 9);
      chk("hd_valid", DW'(ex_valid), 1);
    end
    hold = 0; flush = 0;
    instr(1, 0, 0, 0, 0, 5'd10, 1, 0, 32'h55);
    settle("hd_drop"); clock("hd_drop"); chk("hd_bubble", DW'(ex_valid), 0);
    settle("hd_next"); clock("hd_next");
    chk("hd_next_valid", DW'(ex_valid), 1);
    chk("hd_next_imm", ex_imm, 32'h55);
    chk("hd_next_rd", DW'(ex_rd), 10);

`ifdef HAZARD_STAT_EN
    // Counters: 4 load-use stalls and 2 flushes after a clean reset.
    clr();
    rst_n = 0; #1; model_reset();
    chk("st_rst_s", stat_stall, 0);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      clr();
      instr(1, 0, 0, 0, 0, 5'd3, 1, 1, 32'h0); settle("st_lw"); clock("st_lw");
      instr(1, 0, 5'd3, 0, 1, 5'd4, 1, 0, 32'h0); settle("st_use"); clock("st_use");
    end
    clr();
    instr(1, 0, 0, 0, 0, 5'd2, 1, 0, 32'h0); flush = 1;
    repeat (2) begin settle("st_fl"); clock("st_fl"); end
    chk("st_stall4", stat_stall, 4);
    chk("st_flush2", stat_flush, 2);
    rst_n = 0; #1; model_reset();
    chk("st_rst_stall", stat_stall, 0);
    chk("st_rst_flush", stat_flush, 0);
    @(negedge clk); rst_n = 1;
    clr();
`endif

    // Random traffic against the model, using small register indices so hazards occur often.
    for (int n = 0; n < 400; n++) begin
      instr(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), AW'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom_range(0, 2) == 0), $urandom);
      rf_da = $urandom; rf_db = $urandom; ex_res = $urandom;
      mem_we = 1'($urandom); mem_rd = AW'($urandom_range(0, 3)); mem_data = $urandom;
      wb_we = 1'($urandom); wb_rd = AW'($urandom_range(0, 3)); wb_data = $urandom;
      flush = ($urandom_range(0, 7) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      settle("rnd");
      clock("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
